// File: rtl/cpu_pkg.sv
// Shared constants, ALU operation encoding and instruction encoders for the
// single-cycle RV32I-subset lab core.
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int ROM_AW   = 6;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // ALU_ZERO doubles as the "no legal operation" marker: result 0, no write.
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B,
    ALU_ZERO
  } alu_op_e;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, OPC_OP_IMM};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, OPC_LUI};
  endfunction

endpackage

// File: rtl/single_cycle_cpu_alu.sv
// Purely combinational ALU with zero flag and add/sub signed-overflow flag.
module alu
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            of
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [4:0]      shamt;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[4:0];

  // Select the result; overflow is only meaningful for add and subtract.
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum;
        of     = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        result = diff;
        of     = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      ALU_SLL:    result = a << shamt;
      ALU_SLT:    result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

  assign zf = (result == '0);

endmodule

// File: rtl/single_cycle_cpu.sv
// Single-cycle RV32I-subset core: PC, hard-coded 64-word ROM, decoder,
// register file and ALU. One instruction retires per rising clock edge.
module single_cycle_cpu
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic        io_zf,
  output logic        io_of,
  output logic [31:0] io_aluResult,
  output logic [31:0] io_currentInst,
  output logic [31:0] io_currentPC
);

  // Only 8 PC bits exist: the PC wraps modulo 256 bytes by construction.
  logic [7:0]        pc_q;
  logic [XLEN-1:0]   regs [32];
  logic [31:0]       inst;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   op_b;
  alu_op_e           alu_op;
  logic              reg_we;
  logic [XLEN-1:0]   alu_result;
  logic              alu_zf;
  logic              alu_of;

  // Program ROM: combinational lookup on the word index of the PC.
  always_comb begin
    inst = INST_NOP;
    case (pc_q[7:2])
      6'd0:  inst = enc_u(20'h12345, 5'd1);
      6'd1:  inst = enc_i(12'h678, 5'd1, F3_ADD, 5'd1);
      6'd2:  inst = enc_u(20'h87654, 5'd2);
      6'd3:  inst = enc_i(12'h321, 5'd2, F3_ADD, 5'd2);
      6'd4:  inst = enc_r(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd3);
      6'd5:  inst = enc_r(F7_ALT,  5'd2, 5'd3, F3_ADD, 5'd4);
      6'd6:  inst = enc_u(20'h11111, 5'd5);
      6'd7:  inst = enc_i(12'h111, 5'd5, F3_ADD, 5'd5);
      6'd8:  inst = enc_r(F7_BASE, 5'd4, 5'd5, F3_AND,  5'd6);
      6'd9:  inst = enc_r(F7_BASE, 5'd4, 5'd5, F3_OR,   5'd7);
      6'd10: inst = enc_r(F7_BASE, 5'd4, 5'd5, F3_XOR,  5'd8);
      6'd11: inst = enc_r(F7_BASE, 5'd4, 5'd5, F3_SLTU, 5'd9);
      6'd12: inst = enc_r(F7_BASE, 5'd6, 5'd5, F3_SLL,  5'd10);
      6'd13: inst = enc_i(12'hFFF, 5'd0,  F3_ADD, 5'd11);
      6'd14: inst = enc_i(12'h0FF, 5'd11, F3_AND, 5'd12);
      6'd15: inst = enc_i(12'h0FF, 5'd11, F3_XOR, 5'd13);
      6'd16: inst = enc_i(12'h003, 5'd11, F3_SLL, 5'd14);
      default: inst = INST_NOP;
    endcase
  end

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];
  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};

  // x0 is hard-wired to zero on the read side.
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  // Decode: pick ALU op and operand B; illegal encodings fall back to ALU_ZERO.
  always_comb begin
    alu_op = ALU_ZERO;
    op_b   = rs2_val;
    case (opcode)
      OPC_LUI: begin
        alu_op = ALU_PASS_B;
        op_b   = {inst[31:12], 12'b0};
      end
      OPC_OP_IMM: begin
        op_b = imm_i;
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLTU: alu_op = ALU_SLTU;
          F3_XOR:  alu_op = ALU_XOR;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          F3_SLL:  alu_op = (funct7 == F7_BASE) ? ALU_SLL : ALU_ZERO;
          F3_SR: begin
            if (funct7 == F7_BASE)     alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) alu_op = ALU_SRA;
            else                       alu_op = ALU_ZERO;
          end
          default: alu_op = ALU_ZERO;
        endcase
      end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  alu_op = ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ZERO;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD)     alu_op = ALU_SUB;
          else if (funct3 == F3_SR) alu_op = ALU_SRA;
          else                      alu_op = ALU_ZERO;
        end
      end
      default: alu_op = ALU_ZERO;
    endcase
  end

  assign reg_we = (alu_op != ALU_ZERO) && (rd != 5'd0);

  alu u_alu (
    .a      (rs1_val),
    .b      (op_b),
    .op     (alu_op),
    .result (alu_result),
    .zf     (alu_zf),
    .of     (alu_of)
  );

  // Program counter: advance one word per edge, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_q + 8'd4;
  end

  // Register file: write-back of the ALU result, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[rd] <= alu_result;
    end
  end

  assign io_zf          = alu_zf;
  assign io_of          = alu_of;
  assign io_aluResult   = alu_result;
  assign io_currentInst = inst;
  assign io_currentPC   = {24'b0, pc_q};

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Self-checking bench for single_cycle_cpu plus a standalone ALU instance.
module tb_single_cycle_cpu;
  import cpu_pkg::*;

  localparam int W = 98;  // {pc, inst, result, zf, of}

  logic        clock;
  logic        reset;
  logic        io_zf;
  logic        io_of;
  logic [31:0] io_aluResult;
  logic [31:0] io_currentInst;
  logic [31:0] io_currentPC;

  logic [31:0] ua;
  logic [31:0] ub;
  alu_op_e     uop;
  logic [31:0] ur;
  logic        uz;
  logic        uo;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [32:0]  alu_exp_q[$];

  single_cycle_cpu dut (
    .clock          (clock),
    .reset          (reset),
    .io_zf          (io_zf),
    .io_of          (io_of),
    .io_aluResult   (io_aluResult),
    .io_currentInst (io_currentInst),
    .io_currentPC   (io_currentPC)
  );

  alu u_alu_unit (
    .a      (ua),
    .b      (ub),
    .op     (uop),
    .result (ur),
    .zf     (uz),
    .of     (uo)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  function automatic logic [31:0] prog_inst(input int idx);
    case (idx)
      0:  return 32'h123450B7;
      1:  return 32'h67808093;
      2:  return 32'h87654137;
      3:  return 32'h32110113;
      4:  return 32'h002081B3;
      5:  return 32'h40218233;
      6:  return 32'h111112B7;
      7:  return 32'h11128293;
      8:  return 32'h0042F333;
      9:  return 32'h0042E3B3;
      10: return 32'h0042C433;
      11: return 32'h0042B4B3;
      12: return 32'h00629533;
      13: return 32'hFFF00593;
      14: return 32'h0FF5F613;
      15: return 32'h0FF5C693;
      16: return 32'h00359713;
      default: return 32'h00000013;
    endcase
  endfunction

  function automatic logic [31:0] prog_result(input int idx);
    case (idx)
      0:  return 32'h12345000;
      1:  return 32'h12345678;
      2:  return 32'h87654000;
      3:  return 32'h87654321;
      4:  return 32'h99999999;
      5:  return 32'h12345678;
      6:  return 32'h11111000;
      7:  return 32'h11111111;
      8:  return 32'h10101010;
      9:  return 32'h13355779;
      10: return 32'h03254769;
      11: return 32'h00000001;
      12: return 32'h11110000;
      13: return 32'hFFFFFFFF;
      14: return 32'h000000FF;
      15: return 32'hFFFFFF00;
      16: return 32'hFFFFFFF8;
      default: return 32'h00000000;
    endcase
  endfunction

  // Driver side: record what the core must show while at word idx.
  task automatic push_expected(input int idx);
    logic [31:0] pc;
    logic [31:0] res;
    pc  = idx * 4;
    res = prog_result(idx);
    exp_q.push_back({pc, prog_inst(idx), res, (res == 32'h0), 1'b0});
  endtask

  // Monitor side: pop the oldest expectation and compare all outputs.
  task automatic compare_cycle(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got pc %h, expected an entry", tag, io_currentPC);
      return;
    end
    e = exp_q.pop_front();
    check_val({tag, ".pc"},   io_currentPC,          e[97:66]);
    check_val({tag, ".inst"}, io_currentInst,        e[65:34]);
    check_val({tag, ".res"},  io_aluResult,          e[33:2]);
    check_val({tag, ".zf"},   {31'b0, io_zf},        {31'b0, e[1]});
    check_val({tag, ".of"},   {31'b0, io_of},        {31'b0, e[0]});
  endtask

  task automatic alu_case(input string tag, input alu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic exp_of);
    logic [32:0] e;
    ua  = a;
    ub  = b;
    uop = op;
    alu_exp_q.push_back({exp_of, exp_r});
    #1;
    e = alu_exp_q.pop_front();
    check_val({tag, ".res"}, ur,            e[31:0]);
    check_val({tag, ".of"},  {31'b0, uo},   {31'b0, e[32]});
    check_val({tag, ".zf"},  {31'b0, uz},   {31'b0, (e[31:0] == 32'h0)});
  endtask

  // Random add/sub checked against a 64-bit signed reference.
  task automatic alu_random(input int n);
    logic [31:0] a;
    logic [31:0] b;
    longint      s;
    logic        is_sub;
    logic        ovf;
    for (int i = 0; i < n; i++) begin
      a      = $urandom;
      b      = $urandom;
      is_sub = 1'($urandom_range(0, 1));
      if (is_sub) s = longint'($signed(a)) - longint'($signed(b));
      else        s = longint'($signed(a)) + longint'($signed(b));
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      alu_case($sformatf("alu_rand%0d", i), is_sub ? ALU_SUB : ALU_ADD, a, b, s[31:0], ovf);
    end
  endtask

  initial begin
    int hold;
    reset = 1'b0;
    ua    = '0;
    ub    = '0;
    uop   = ALU_ZERO;

    // Held in reset: outputs must show word 0 regardless of clocking.
    repeat (10) begin
      @(negedge clock);
      push_expected(0);
      compare_cycle("reset");
    end
    reset = 1'b1;

    // Full ROM sweep including the NOP region.
    for (int k = 0; k < 64; k++) begin
      push_expected(k);
      compare_cycle($sformatf("run%0d", k));
      @(negedge clock);
    end

    // After wrap: PC back at 0, run to 0x20.
    for (int k = 0; k < 8; k++) begin
      push_expected(k);
      compare_cycle($sformatf("wrap%0d", k));
      @(negedge clock);
    end
    push_expected(8);
    compare_cycle("at20");

    // Asynchronous reset between edges.
    reset = 1'b0;
    #1;
    push_expected(0);
    compare_cycle("midreset");
    hold = $urandom_range(1, 3);
    repeat (hold) begin
      @(negedge clock);
      push_expected(0);
      compare_cycle("hold");
    end
    reset = 1'b1;

    // Re-execution from word 0 with rebuilt registers.
    for (int k = 0; k < 18; k++) begin
      push_expected(k);
      compare_cycle($sformatf("rerun%0d", k));
      @(negedge clock);
    end

    // Standalone ALU checks.
    alu_case("add_ovf", ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1);
    alu_case("sub_ovf", ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1);
    alu_case("sra",     ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0);
    alu_case("slt",     ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
    alu_case("sltu",    ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    alu_case("srl",     ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0);
    alu_case("zero",    ALU_ZERO, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0);
    alu_random(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
